roi_cfg_ctrl: RTL and testbench
===============================

# roi_cfg_ctrl

Frame-synchronous configuration controller for the ROI crop core. Accepts ROI corner writes from the host side, validates and normalises them, holds one pending configuration and commits it to the crop core's `xy_0_i`/`xy_1_i` only between frames. This keeps the crop window constant for every beat of a frame. It watches the same input stream handshake the crop core consumes and reports frame count, activity and configuration errors.

## Interface
- `BIT_C`, 32: width of coordinate words. Format is x[26:16], y[9:0]; all other bits are zero.
- `IMG_W`, 640: input frame width in pixels. Must be ≤ 2048.
- `IMG_H`, 480: input frame height in lines. Must be ≤ 1024.
- `BIT_F`, 16: width of the frame counter.

Ports:
- `clk_i` in 1: single clock.
- `arst_i` in 1: asynchronous reset, active-high.
- `cfg_wr_i` in 1: host write strobe, one cycle per write.
- `cfg_xy_0_i` in BIT_C: first corner.
- `cfg_xy_1_i` in BIT_C: second corner.
- `cfg_ready_o` out 1: pending slot free.
- `tvalid_i` in 1: input stream valid (monitor only).
- `tlast_i` in 1: input stream last beat of frame (monitor only).
- `xy_0_o` out BIT_C: active top-left corner, drives crop core `xy_0_i`.
- `xy_1_o` out BIT_C: active bottom-right corner, drives crop core `xy_1_i`.
- `busy_o` out 1: frame in progress.
- `frame_cnt_o` out BIT_F: completed frames, wraps.
- `cfg_err_o` out 2: [0] range error, [1] overflow. Each is a 1-cycle pulse.

## Operation
- Normalisation, applied at write time:
  - x0n = min(x0,x1), x1n = max(x0,x1); same for y.
  - Reserved bits are forced to 0.
- Range check: reject the write if x1n ≥ IMG_W or y1n ≥ IMG_H. On reject, pulse `cfg_err_o[0]` and store nothing.
- Overflow: a write while `cfg_ready_o`=0 is dropped and pulses `cfg_err_o[1]`. Range is not checked in this case.
- FSM has two states:
  - IDLE → ACTIVE on `tvalid_i` & !`tlast_i`.
  - ACTIVE → IDLE on `tvalid_i` & `tlast_i`.
  - A beat with `tvalid_i` & `tlast_i` in IDLE is a single-beat frame: the FSM stays in IDLE.
- Commit points, where the pending configuration moves to `xy_*_o` and the pending slot clears:
  - (a) the edge closing a last beat (`tvalid_i` & `tlast_i`), in either state;
  - (b) any IDLE cycle with `tvalid_i`=0.
- Direct path: a valid write in IDLE with `tvalid_i`=0 and the pending slot empty goes straight to `xy_*_o`. It never occupies the pending slot.
- A valid write in ACTIVE goes to the pending slot. So does a valid write in the same cycle as a first beat in IDLE: that frame uses the old window.
- `frame_cnt_o` increments on every `tvalid_i` & `tlast_i` and wraps from 2^BIT_F−1 to 0.
- `busy_o` = (state == ACTIVE).
- `cfg_ready_o` = !pending_valid, a registered flag.
- Write coincident with commit (a) while the slot is full: `cfg_ready_o` is sampled low, so the write is an overflow and is dropped. The old pending entry still commits.

## Timing
- Reset values:
  - `xy_0_o`=0.
  - `xy_1_o`={(IMG_W−1) at [26:16], (IMG_H−1) at [9:0]}.
  - `busy_o`=0, `frame_cnt_o`=0, `cfg_err_o`=0, `cfg_ready_o`=1.
  - pending slot empty, state IDLE.
- Reset asserted mid-frame discards the pending entry and the frame. Outputs return to reset values immediately, asynchronously.
- Direct write: `xy_*_o` is updated at the edge after `cfg_wr_i`, so latency is 1.
- Commit (a): new `xy_*_o` is valid in the cycle after the last beat. A back-to-back next frame's first beat sees the new window.
- Error pulses: asserted the cycle after the offending `cfg_wr_i`, for 1 cycle.
- `frame_cnt_o` and `busy_o`: updated the cycle after the triggering beat.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset, IMG 640×480: `xy_0_o`=0x0000_0000, `xy_1_o`=0x027F_01DF, `cfg_ready_o`=1.
- Idle write xy_0=0x00C8_0064, xy_1=0x0032_0014 → next cycle `xy_0_o`=0x0032_0014, `xy_1_o`=0x00C8_0064 (swapped).
- Write during ACTIVE frame: outputs unchanged through the frame, `cfg_ready_o`=0. The cycle after the tlast beat the new window appears, `cfg_ready_o`=1, `frame_cnt_o`+1.
- Two writes in one frame: second gives `cfg_err_o`=2'b10. The first write commits at frame end.
- Write xy_1 x=640: `cfg_err_o`=2'b01, outputs and pending unchanged.
- Assert `arst_i` mid-frame with a pending entry → all outputs return to reset values. The next frame uses the default window.

Source files
------------

// File: rtl/roi_cfg_if.sv
// Host configuration and stream-monitor bundle for roi_cfg_ctrl.
// The controller sits on the slave side; the host/stream source is the master.
interface roi_cfg_if #(
  parameter int BIT_C = 32,
  parameter int BIT_F = 16
);
  logic             cfg_wr_i;
  logic [BIT_C-1:0] cfg_xy_0_i;
  logic [BIT_C-1:0] cfg_xy_1_i;
  logic             cfg_ready_o;
  logic             tvalid_i;
  logic             tlast_i;
  logic [BIT_C-1:0] xy_0_o;
  logic [BIT_C-1:0] xy_1_o;
  logic             busy_o;
  logic [BIT_F-1:0] frame_cnt_o;
  logic [1:0]       cfg_err_o;

  modport slave (
    input  cfg_wr_i, cfg_xy_0_i, cfg_xy_1_i, tvalid_i, tlast_i,
    output cfg_ready_o, xy_0_o, xy_1_o, busy_o, frame_cnt_o, cfg_err_o
  );

  modport master (
    output cfg_wr_i, cfg_xy_0_i, cfg_xy_1_i, tvalid_i, tlast_i,
    input  cfg_ready_o, xy_0_o, xy_1_o, busy_o, frame_cnt_o, cfg_err_o
  );
endinterface

// File: rtl/roi_cfg_ctrl.sv
// Frame-synchronous ROI window controller: normalises and range-checks host
// corner writes, holds one pending window and swaps it in only between frames.
module roi_cfg_ctrl #(
  parameter int BIT_C = 32,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int BIT_F = 16
) (
  input  logic      clk_i,
  input  logic      arst_i,
  roi_cfg_if.slave  bus
);

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  function automatic logic [BIT_C-1:0] pack(input logic [10:0] x, input logic [9:0] y);
    logic [BIT_C-1:0] v;
    v        = '0;
    v[26:16] = x;
    v[9:0]   = y;
    return v;
  endfunction

  localparam logic [BIT_C-1:0] XY1_RST = pack(11'(IMG_W - 1), 10'(IMG_H - 1));

  state_t           r_state;
  logic             r_pend_v;
  logic [BIT_C-1:0] r_pend_0, r_pend_1;
  logic [BIT_C-1:0] r_xy_0, r_xy_1;
  logic [BIT_F-1:0] r_fcnt;
  logic [1:0]       r_err;

  logic [10:0] w_xa, w_xb, w_x0n, w_x1n;
  logic [9:0]  w_ya, w_yb, w_y0n, w_y1n;
  logic        w_range_bad, w_last, w_quiet, w_commit, w_wr_ok;
  logic [BIT_C-1:0] w_new_0, w_new_1;
  logic        w_unused_bits;

  assign w_xa  = bus.cfg_xy_0_i[26:16];
  assign w_xb  = bus.cfg_xy_1_i[26:16];
  assign w_ya  = bus.cfg_xy_0_i[9:0];
  assign w_yb  = bus.cfg_xy_1_i[9:0];
  assign w_x0n = (w_xa < w_xb) ? w_xa : w_xb;
  assign w_x1n = (w_xa < w_xb) ? w_xb : w_xa;
  assign w_y0n = (w_ya < w_yb) ? w_ya : w_yb;
  assign w_y1n = (w_ya < w_yb) ? w_yb : w_ya;
  assign w_new_0 = pack(w_x0n, w_y0n);
  assign w_new_1 = pack(w_x1n, w_y1n);

  assign w_unused_bits = ^{bus.cfg_xy_0_i[BIT_C-1:27], bus.cfg_xy_0_i[15:10],
                           bus.cfg_xy_1_i[BIT_C-1:27], bus.cfg_xy_1_i[15:10]};

  // Extra MSB so IMG_W = 2048 / IMG_H = 1024 never flag a legal coordinate.
  assign w_range_bad = ({1'b0, w_x1n} >= 12'(IMG_W)) || ({1'b0, w_y1n} >= 11'(IMG_H));

  // Quiet idle cycles and the edge closing a last beat are the only safe swap points.
  assign w_last   = bus.tvalid_i & bus.tlast_i;
  assign w_quiet  = (r_state == S_IDLE) & ~bus.tvalid_i;
  assign w_commit = w_last | w_quiet;
  assign w_wr_ok  = bus.cfg_wr_i & ~r_pend_v & ~w_range_bad;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state  <= S_IDLE;
      r_pend_v <= 1'b0;
      r_pend_0 <= '0;
      r_pend_1 <= '0;
      r_xy_0   <= '0;
      r_xy_1   <= XY1_RST;
      r_fcnt   <= '0;
      r_err    <= 2'b00;
    end else begin
      r_err <= {bus.cfg_wr_i & r_pend_v, bus.cfg_wr_i & ~r_pend_v & w_range_bad};
      if (w_last) r_fcnt <= r_fcnt + BIT_F'(1);

      case (r_state)
        S_IDLE:   if (bus.tvalid_i & ~bus.tlast_i) r_state <= S_ACTIVE;
        S_ACTIVE: if (w_last) r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase

      if (w_commit && r_pend_v) begin
        r_xy_0   <= r_pend_0;
        r_xy_1   <= r_pend_1;
        r_pend_v <= 1'b0;
      end

      // w_wr_ok implies the slot was empty, so it never collides with the commit above.
      if (w_wr_ok) begin
        if (w_quiet) begin
          r_xy_0 <= w_new_0;
          r_xy_1 <= w_new_1;
        end else begin
          r_pend_0 <= w_new_0;
          r_pend_1 <= w_new_1;
          r_pend_v <= 1'b1;
        end
      end
    end
  end

  assign bus.xy_0_o      = r_xy_0;
  assign bus.xy_1_o      = r_xy_1;
  assign bus.busy_o      = (r_state == S_ACTIVE);
  assign bus.frame_cnt_o = r_fcnt;
  assign bus.cfg_err_o   = r_err;
  assign bus.cfg_ready_o = ~r_pend_v;

endmodule

// File: tb/tb_roi_cfg_ctrl.sv
// Bench for roi_cfg_ctrl: directed frames/writes with literal checks plus a
// cycle-by-cycle window model compared on every falling edge.
module tb_roi_cfg_ctrl;
  localparam int IMG_W = 640;
  localparam int IMG_H = 480;

  logic clk  = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  roi_cfg_if #(.BIT_C(32), .BIT_F(16)) bus ();
  roi_cfg_ctrl #(.BIT_C(32), .IMG_W(IMG_W), .IMG_H(IMG_H), .BIT_F(16)) dut (
    .clk_i(clk), .arst_i(arst), .bus(bus)
  );

  int vec  = 0;
  int miss = 0;
  bit started = 0;

  typedef struct { int x0, y0, x1, y1; } win_t;
  win_t pq[$];
  win_t mw;
  bit   mact;
  int   mfc;
  logic [1:0] merr;

  function automatic logic [31:0] pk(input int x, input int y);
    return {5'b0, x[10:0], 6'b0, y[9:0]};
  endfunction

  task automatic mreset();
    mw = '{0, 0, IMG_W - 1, IMG_H - 1};
    mact = 0; mfc = 0; merr = 2'b00;
    pq.delete();
  endtask

  // Reference: the window the crop core sees, derived from the frame rules.
  initial begin
    mreset();
    forever begin
      @(posedge clk or posedge arst);
      if (arst) mreset();
      else begin
        bit tv, tl, wr, quiet, had_room;
        int ax, bx, ay, by;
        win_t nw;
        tv = bus.tvalid_i; tl = bus.tlast_i; wr = bus.cfg_wr_i;
        quiet = !mact && !tv;
        had_room = (pq.size() == 0);
        merr = 2'b00;
        if (((tv && tl) || quiet) && !had_room) mw = pq.pop_front();
        if (wr) begin
          ax = int'(bus.cfg_xy_0_i[26:16]); bx = int'(bus.cfg_xy_1_i[26:16]);
          ay = int'(bus.cfg_xy_0_i[9:0]);   by = int'(bus.cfg_xy_1_i[9:0]);
          nw.x0 = (ax < bx) ? ax : bx; nw.x1 = (ax < bx) ? bx : ax;
          nw.y0 = (ay < by) ? ay : by; nw.y1 = (ay < by) ? by : ay;
          if (!had_room) merr = 2'b10;
          else if (nw.x1 >= IMG_W || nw.y1 >= IMG_H) merr = 2'b01;
          else if (quiet) mw = nw;
          else pq.push_back(nw);
        end
        if (tv && tl) mfc = (mfc + 1) % 65536;
        if (tv) mact = !tl;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        vec++;
        if (bus.xy_0_o !== pk(mw.x0, mw.y0)) begin
          miss++; $display("FAIL model xy_0 t=%0t got %h want %h", $time, bus.xy_0_o, pk(mw.x0, mw.y0));
        end
        if (bus.xy_1_o !== pk(mw.x1, mw.y1)) begin
          miss++; $display("FAIL model xy_1 t=%0t got %h want %h", $time, bus.xy_1_o, pk(mw.x1, mw.y1));
        end
        if (bus.cfg_ready_o !== (pq.size() == 0)) begin
          miss++; $display("FAIL model ready t=%0t got %b want %b", $time, bus.cfg_ready_o, pq.size() == 0);
        end
        if (bus.busy_o !== mact) begin
          miss++; $display("FAIL model busy t=%0t got %b want %b", $time, bus.busy_o, mact);
        end
        if (bus.frame_cnt_o !== 16'(mfc)) begin
          miss++; $display("FAIL model frame_cnt t=%0t got %0d want %0d", $time, bus.frame_cnt_o, mfc);
        end
        if (bus.cfg_err_o !== merr) begin
          miss++; $display("FAIL model err t=%0t got %b want %b", $time, bus.cfg_err_o, merr);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit tv, input bit tl, input bit wr,
                       input logic [31:0] a, input logic [31:0] b);
    bus.tvalid_i = tv; bus.tlast_i = tl; bus.cfg_wr_i = wr;
    bus.cfg_xy_0_i = a; bus.cfg_xy_1_i = b;
    tick();
    bus.cfg_wr_i = 1'b0;
  endtask

  task automatic do_reset();
    #2 arst = 1'b1;
    #1;
    chk("rst xy_0", bus.xy_0_o, 32'h0000_0000);
    chk("rst xy_1", bus.xy_1_o, 32'h027F_01DF);
    chk("rst ready", 32'(bus.cfg_ready_o), 32'd1);
    chk("rst busy", 32'(bus.busy_o), 32'd0);
    chk("rst fcnt", 32'(bus.frame_cnt_o), 32'd0);
    chk("rst err", 32'(bus.cfg_err_o), 32'd0);
    repeat (2) @(posedge clk);
    #3 arst = 1'b0;
    tick();
  endtask

  initial begin
    bus.cfg_wr_i = 0; bus.cfg_xy_0_i = 0; bus.cfg_xy_1_i = 0;
    bus.tvalid_i = 0; bus.tlast_i = 0;
    #1 arst = 1'b1;
    repeat (2) @(posedge clk);
    #3 arst = 1'b0;
    started = 1;
    tick();
    chk("reset xy_0", bus.xy_0_o, 32'h0000_0000);
    chk("reset xy_1", bus.xy_1_o, 32'h027F_01DF);
    chk("reset ready", 32'(bus.cfg_ready_o), 32'd1);

    // Idle direct write with swapped corners
    drive(0, 0, 1, 32'h00C8_0064, 32'h0032_0014);
    chk("direct xy_0", bus.xy_0_o, 32'h0032_0014);
    chk("direct xy_1", bus.xy_1_o, 32'h00C8_0064);

    // Write during frame, then overflow, commit at tlast
    drive(1, 0, 0, 0, 0);
    chk("busy", 32'(bus.busy_o), 32'd1);
    drive(1, 0, 1, 32'h0010_0020, 32'h0100_0080);
    chk("pend ready", 32'(bus.cfg_ready_o), 32'd0);
    chk("pend xy_0 held", bus.xy_0_o, 32'h0032_0014);
    drive(0, 0, 0, 0, 0);
    chk("gap xy_1 held", bus.xy_1_o, 32'h00C8_0064);
    drive(1, 0, 1, 32'h0001_0001, 32'h0002_0002);
    chk("overflow err", 32'(bus.cfg_err_o), 32'd2);
    drive(1, 1, 0, 0, 0);
    chk("commit xy_0", bus.xy_0_o, 32'h0010_0020);
    chk("commit xy_1", bus.xy_1_o, 32'h0100_0080);
    chk("commit ready", 32'(bus.cfg_ready_o), 32'd1);
    chk("commit fcnt", 32'(bus.frame_cnt_o), 32'd1);
    chk("commit idle", 32'(bus.busy_o), 32'd0);

    // Range boundaries
    drive(0, 0, 1, 32'h0000_0000, 32'h0280_0010);
    chk("range x err", 32'(bus.cfg_err_o), 32'd1);
    chk("range x held", bus.xy_1_o, 32'h0100_0080);
    drive(0, 0, 1, 32'h0000_01E0, 32'h0000_0000);
    chk("range y err", 32'(bus.cfg_err_o), 32'd1);
    drive(0, 0, 1, 32'h027F_01DF, 32'h0000_0000);
    chk("edge ok err", 32'(bus.cfg_err_o), 32'd0);
    chk("edge ok xy_1", bus.xy_1_o, 32'h027F_01DF);

    // Reserved bits dropped
    drive(0, 0, 1, 32'hF80A_FC05, 32'h0003_0007);
    chk("rsvd xy_0", bus.xy_0_o, 32'h0003_0005);
    chk("rsvd xy_1", bus.xy_1_o, 32'h000A_0007);

    // Single-beat frame with coincident write: old window for that frame
    drive(1, 1, 1, 32'h0005_0005, 32'h0006_0006);
    chk("single fcnt", 32'(bus.frame_cnt_o), 32'd2);
    chk("single held", bus.xy_0_o, 32'h0003_0005);
    chk("single pend", 32'(bus.cfg_ready_o), 32'd0);
    drive(0, 0, 0, 0, 0);
    chk("idle commit", bus.xy_0_o, 32'h0005_0005);

    // Write at tlast with slot full, then back-to-back frame
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 1, 32'h0007_0007, 32'h0008_0008);
    drive(1, 1, 1, 32'h0009_0009, 32'h000A_000A);
    chk("tlast ovf err", 32'(bus.cfg_err_o), 32'd2);
    chk("tlast ovf commit", bus.xy_0_o, 32'h0007_0007);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    chk("b2b fcnt", 32'(bus.frame_cnt_o), 32'd4);
    drive(0, 0, 0, 0, 0);

    // Reset mid-frame with pending entry
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 1, 32'h0011_0011, 32'h0022_0022);
    do_reset();
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    chk("post-rst xy_1", bus.xy_1_o, 32'h027F_01DF);
    chk("post-rst fcnt", 32'(bus.frame_cnt_o), 32'd1);

    // Pseudo-random mix checked by the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = pk(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)));
      b = pk(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)));
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0, a, b);
    end
    drive(0, 0, 0, 0, 0);

    // Frame counter wrap
    do_reset();
    bus.tvalid_i = 1; bus.tlast_i = 1;
    repeat (65535) @(posedge clk);
    #1 chk("fcnt max", 32'(bus.frame_cnt_o), 32'h0000_FFFF);
    tick();
    chk("fcnt wrap", 32'(bus.frame_cnt_o), 32'd0);
    bus.tvalid_i = 0; bus.tlast_i = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
